// File: rtl/param_rx_fifo_pkg.sv
// Shared helpers for the parametrised receive FIFO: count width,
// pointer increment with wrap, and default flag thresholds.
package rx_fifo_pkg;

    // Default almost-empty threshold and almost-full distance from DEPTH
    localparam int DEF_AE_LEVEL  = 1;
    localparam int DEF_AF_MARGIN = 2;

    // Width needed to hold an occupancy of 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Advance a pointer, wrapping at depth-1 by explicit compare so that
    // non-power-of-two depths work
    function automatic int unsigned ptr_next(input int unsigned p, input int unsigned depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/param_rx_fifo_if.sv
// Bus between the receive front end / command decoder and the FIFO.
interface param_rx_fifo_if
    import rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = cnt_width(DEPTH)
);
    logic                  clear;
    logic                  w_enable;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_enable;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, w_enable, w_data, r_enable,
        input  r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  clear, w_enable, w_data, r_enable,
        output r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/param_rx_fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    // Store the incoming word at the write address
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/param_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy count, programmable
// almost flags, synchronous flush and sticky overflow/underflow.
module param_rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL   = DEF_AE_LEVEL,
    parameter int CNT_W      = cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            n_rst,
    param_rx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic empty_q, empty_d, full_q, full_d;
    logic ae_q, ae_d, af_q, af_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic wr_acc, rd_acc, mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q),
        .wdata (bus.w_data),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    // Accept/reject decisions, next pointers, count, flags and sticky errors
    always_comb begin
        // A write into a full FIFO still fits when the head is popped the same cycle
        wr_acc  = bus.w_enable & (~full_q | bus.r_enable);
        rd_acc  = bus.r_enable & ~empty_q;
        mem_we  = wr_acc & ~bus.clear;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (bus.w_enable & full_q & ~bus.r_enable);
        unf_d   = unf_q | (bus.r_enable & empty_q);

        if (bus.clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = PTR_W'(ptr_next(32'(wptr_q), DEPTH));
            if (rd_acc) rptr_d = PTR_W'(ptr_next(32'(rptr_q), DEPTH));
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        ae_d    = (count_d <= AE_C);
        af_d    = (count_d >= AF_C);
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.r_data       = empty_q ? '0 : mem_rdata;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_param_rx_fifo.sv
// Scoreboard bench for param_rx_fifo (DEPTH=8, DATA_WIDTH=8, default thresholds).
module tb_param_rx_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AF = DEPTH - 2;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int n_asserts = 0;
    int n_fails = 0;

    logic [DW-1:0] sb[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    param_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    param_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare every output against the scoreboard model
    task automatic check_state(input string tag);
        int c;
        c = sb.size();
        check({tag, ".count"}, 32'(bus.count), 32'(c));
        check({tag, ".empty"}, 32'(bus.empty), 32'(c == 0));
        check({tag, ".full"},  32'(bus.full),  32'(c == DEPTH));
        check({tag, ".ae"},    32'(bus.almost_empty), 32'(c <= AE));
        check({tag, ".af"},    32'(bus.almost_full),  32'(c >= AF));
        check({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(bus.underflow), 32'(m_unf));
        check({tag, ".rdata"}, 32'(bus.r_data), (c == 0) ? 32'h0 : 32'(sb[0]));
    endtask

    // One clock: drive request, check popped word, update model, check state
    task automatic step(input string tag, input bit we, input logic [DW-1:0] wd,
                        input bit re, input bit clr);
        bit m_full, m_empty, wr, rd;
        bus.w_enable = we;
        bus.w_data   = wd;
        bus.r_enable = re;
        bus.clear    = clr;
        m_full  = (sb.size() == DEPTH);
        m_empty = (sb.size() == 0);
        if (clr) begin
            sb.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            rd = re && !m_empty;
            wr = we && (!m_full || re);
            if (we && m_full && !re) m_ovf = 1;
            if (re && m_empty) m_unf = 1;
            if (rd) begin
                check({tag, ".pop"}, 32'(bus.r_data), 32'(sb[0]));
                void'(sb.pop_front());
            end
            if (wr) sb.push_back(wd);
        end
        @(posedge clk);
        #1;
        bus.w_enable = 1'b0;
        bus.r_enable = 1'b0;
        bus.clear    = 1'b0;
        check_state(tag);
    endtask

    initial begin
        bus.w_enable = 1'b0;
        bus.w_data   = '0;
        bus.r_enable = 1'b0;
        bus.clear    = 1'b0;

        // Reset then idle
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        check_state("reset");
        step("idle", 0, 8'h00, 0, 0);

        // Fill and latency
        step("wr_ff", 1, 8'hFF, 0, 0);
        for (int i = 1; i < 8; i++) step("fill", 1, DW'(i), 0, 0);

        // Overflow then drain
        step("ovf", 1, 8'hAA, 0, 0);
        for (int i = 0; i < 8; i++) step("drain", 0, 8'h00, 1, 0);

        // Wrap with concurrent read+write at constant occupancy
        for (int i = 0; i < 3; i++) step("pre", 1, DW'(8'h10 + i), 0, 0);
        for (int i = 0; i < 20; i++) step("rw", 1, DW'(8'h20 + i), 1, 0);
        for (int i = 0; i < 3; i++) step("drain2", 0, 8'h00, 1, 0);

        // Empty corner
        step("unf", 0, 8'h00, 1, 0);
        step("rw_empty", 1, 8'h5C, 1, 0);

        // Full + simultaneous read/write keeps full
        for (int i = 0; i < 7; i++) step("fill2", 1, DW'(8'h40 + i), 0, 0);
        step("rw_full", 1, 8'h77, 1, 0);
        step("ovf2", 1, 8'h99, 0, 0);

        // Flush at count 5 with a write that must be ignored
        for (int i = 0; i < 3; i++) step("to5", 0, 8'h00, 1, 0);
        check("cnt5", 32'(bus.count), 32'd5);
        step("clear", 1, 8'hEE, 0, 1);
        step("post_clr", 1, 8'h33, 0, 0);

        // Asynchronous reset mid-cycle at count 5
        for (int i = 0; i < 4; i++) step("to5b", 1, DW'(8'h60 + i), 0, 0);
        #2;
        n_rst = 1'b0;
        sb.delete();
        m_ovf = 0;
        m_unf = 0;
        #1;
        check_state("async_rst");
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("after_rst");
        step("wr_after_rst", 1, 8'hC3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule

// File: doc/param_rx_fifo.md
Name: param_rx_fifo

Overview:
Parametrised receive FIFO that succeeds the fixed 8-bit single-entry-width receive FIFO. It generalises data width and depth, and it is first-word-fall-through: the head word is always presented on r_data. It adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between the serial receive front end and the GPU command decoder.

Parameters:
- DATA_WIDTH, default 8: width of w_data and r_data in bits; must be ≥1.
- DEPTH, default 8: number of storage entries; must be ≥2; need not be a power of 2.
- AF_LEVEL, default DEPTH-2: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, default 1: almost_empty asserts when count ≤ AE_LEVEL.
- CNT_W, default $clog2(DEPTH+1): width of count; derived, not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- w_enable  in  1  write request.
- w_data  in  DATA_WIDTH  write data.
- r_enable  in  1  read request (pop the head word).
- r_data  out  DATA_WIDTH  head word (FWFT); all zeros while empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count ≤ AE_LEVEL.
- almost_full  out  1  count ≥ AF_LEVEL.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a rejected write.
- underflow  out  1  sticky; set by a rejected read.

Behaviour:
- Reset (n_rst=0, asynchronous): wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, r_data=0. Storage contents are not reset.
- clear=1 at an edge: same state as reset except storage; w_enable and r_enable are ignored that cycle; the sticky flags are cleared.
- Write accepted when w_enable & (!full | r_enable). The word is stored at mem[wptr]; wptr advances.
- Read accepted when r_enable & !empty. rptr advances; the popped word was visible on r_data before the edge.
- Simultaneous read and write:
  - Not empty and not full: both accepted; count unchanged.
  - Full: both accepted; full stays 1.
  - Empty: write accepted; read rejected and underflow set; count becomes 1.
- w_enable & full & !r_enable: write dropped, overflow set, state unchanged.
- r_enable & empty: underflow set, state unchanged.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. This uses explicit compare, not modulo by power of 2.
- count: +1 on a write-only cycle, −1 on a read-only cycle, unchanged on both-or-neither. It never exceeds DEPTH and never goes below 0.
- Flags are registered, derived from next-state count, and valid in the same cycle as count.
- Latency: a word written at edge N appears on r_data after edge N when the FIFO was empty (1-cycle write-to-read latency). Otherwise it appears after all earlier words are popped.
- r_data = empty ? 0 : mem[rptr]. This is a combinational read of registered storage.
- Sticky flags hold until reset or clear.

Decomposition:
- Package rx_fifo_pkg: the function for count-width computation, the pointer-increment-with-wrap function, and the default threshold constants.
- Sub-module fifo_regfile: DEPTH×DATA_WIDTH register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). It has no reset.
- Top level: pointers, count, flags and error logic.

Test Plan:
- Reset then idle: hold n_rst=0 for 1 cycle, release → empty=1, count=0, r_data=8'h00, all other flags 0 except almost_empty=1.
- Fill and latency: write 8'hFF at edge 1 → r_data=8'hFF and count=1 after that edge. Write 8'h01..8'h07 → full=1, count=8, almost_full=1 from count=6.
- Overflow: while full, write 8'hAA with r_enable=0 → overflow=1, count=8. Drain → 8'hFF,01..07 in order, no 8'hAA.
- Wrap and concurrency: with count=3, apply 20 cycles of simultaneous read+write with incrementing data → count stays 3, output order is preserved across pointer wrap.
- Empty corner: while empty, read alone → underflow=1. Read+write 8'h5C together → count=1, r_data=8'h5C.
- Flush and mid-operation reset: at count=5 assert clear with w_enable=1 → count=0, empty=1, flags cleared, write ignored. Repeat with n_rst pulsed mid-cycle → outputs go to reset values immediately, without waiting for a clock edge.
